oam_dma_engine: RTL and testbench

- Bus-side initiator for the PPU's OAM DMA port. It owns the DMA register (CPU address FF46) and takes over the CPU bus while `dma_active` is high.
- Each transfer copies LEN bytes from `{src_hi, 8'h00}` into OAM indices 0..LEN-1, one byte per BYTE_CYCLES clocks.
- Sits between the CPU bus arbiter, which honours `dma_active`, and the PPU's OAM write port.

---
 rtl/oam_dma_if.sv | 24 ++
 rtl/oam_dma_engine.sv | 114 +++++++++++
 tb/tb_oam_dma_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA engine, the CPU register port, the bus and the PPU OAM port.
interface oam_dma_if;
  logic        reg_write;
  logic [7:0]  reg_d_wr;
  logic [7:0]  reg_d_rd;
  logic        dma_active;
  logic [15:0] dma_src_addr;
  logic        bus_rd;
  logic [7:0]  bus_d_in;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d_wr;
  logic        oam_write;
  logic        done;

  modport master (
    input  reg_write, reg_d_wr, bus_d_in,
    output reg_d_rd, dma_active, dma_src_addr, bus_rd, oam_addr, oam_d_wr, oam_write, done
  );

  modport slave (
    output reg_write, reg_d_wr, bus_d_in,
    input  reg_d_rd, dma_active, dma_src_addr, bus_rd, oam_addr, oam_d_wr, oam_write, done
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA initiator: copies LEN bytes from {src_hi, 8'h00} into OAM, one byte per BYTE_CYCLES.
module oam_dma_engine #(
  parameter int unsigned LEN         = 160,
  parameter int unsigned BYTE_CYCLES = 4,
  parameter int unsigned START_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  oam_dma_if.master   io_bus
);

  localparam int unsigned SlotW   = $clog2(BYTE_CYCLES);
  localparam int unsigned WaitMax = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  localparam int unsigned WaitW   = (WaitMax > 0) ? $clog2(WaitMax + 1) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(BYTE_CYCLES - 1);
  localparam logic [SlotW-1:0] SlotOne  = SlotW'(1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WaitMax);
  localparam logic [7:0]       IdxLast  = 8'(LEN - 1);

  typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

  state_e            r_state, w_state_d;
  logic [7:0]        r_idx, w_idx_d;
  logic [SlotW-1:0]  r_slot, w_slot_d;
  logic [WaitW-1:0]  r_wait, w_wait_d;
  logic [7:0]        r_src_hi, w_src_hi_d;
  logic [7:0]        r_raw, w_raw_d;
  logic              r_done, w_done_d;
  logic              w_bus_rd;
  logic              w_oam_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_slot   <= '0;
      r_wait   <= '0;
      r_src_hi <= '0;
      r_raw    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_slot   <= w_slot_d;
      r_wait   <= w_wait_d;
      r_src_hi <= w_src_hi_d;
      r_raw    <= w_raw_d;
      r_done   <= w_done_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_slot_d    = r_slot;
    w_wait_d    = r_wait;
    w_src_hi_d  = r_src_hi;
    w_raw_d     = r_raw;
    w_done_d    = 1'b0;
    w_bus_rd    = 1'b0;
    w_oam_write = 1'b0;

    unique case (r_state)
      StIdle: ;
      StStart: begin
        if (r_wait == WaitLast) begin
          w_state_d = StXfer;
          w_wait_d  = '0;
        end else begin
          w_wait_d = r_wait + WaitW'(1);
        end
      end
      StXfer: begin
        w_bus_rd    = (r_slot == '0);
        // A restart landing on the write slot drops that byte.
        w_oam_write = (r_slot == SlotOne) && !io_bus.reg_write;
        if (r_slot == SlotLast) begin
          w_slot_d = '0;
          if (r_idx == IdxLast) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d = r_idx + 8'd1;
          end
        end else begin
          w_slot_d = r_slot + SlotW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // A register write restarts from any state and overrides completion.
    if (io_bus.reg_write) begin
      w_raw_d    = io_bus.reg_d_wr;
      w_src_hi_d = (io_bus.reg_d_wr >= 8'hE0) ? io_bus.reg_d_wr - 8'h20 : io_bus.reg_d_wr;
      w_idx_d    = '0;
      w_slot_d   = '0;
      w_wait_d   = '0;
      w_done_d   = 1'b0;
      w_state_d  = (START_DELAY == 0) ? StXfer : StStart;
    end
  end

  assign io_bus.dma_active   = (r_state != StIdle);
  assign io_bus.dma_src_addr = {r_src_hi, r_idx};
  assign io_bus.bus_rd       = w_bus_rd;
  assign io_bus.oam_write    = w_oam_write;
  assign io_bus.oam_addr     = r_idx;
  assign io_bus.oam_d_wr     = w_oam_write ? io_bus.bus_d_in : 8'h00;
  assign io_bus.reg_d_rd     = r_raw;
  assign io_bus.done         = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: per-cycle reference model plus directed corner sequences.
module tb_oam_dma_engine;
  localparam int unsigned LEN = 160;
  localparam int unsigned BC  = 4;
  localparam int unsigned SD  = 4;
  localparam int unsigned ACT = SD + LEN * BC;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  oam_dma_if bus ();
  oam_dma_if bus2 ();

  oam_dma_engine #(.LEN(LEN), .BYTE_CYCLES(BC), .START_DELAY(SD)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.master)
  );

  oam_dma_engine #(.LEN(160), .BYTE_CYCLES(2), .START_DELAY(0)) dut2 (
    .clk    (clk),
    .reset  (reset2),
    .io_bus (bus2.master)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transfer position is just "cycles since the accepted write".
  bit          m_active;
  int          m_k;
  logic [7:0]  m_src;
  logic [7:0]  m_raw;
  bit          m_done;
  bit          prev_rd;
  logic [15:0] prev_addr;

  int          cyc;
  int          n_active, n_done, n_wr;
  int          wr_cyc[$];
  logic [7:0]  oam [256];
  logic [15:0] min_addr, max_addr;

  typedef struct {
    logic [7:0] d;
    logic [7:0] exp_hi;
  } map_vec_t;

  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    n_active = 0;
    n_done   = 0;
    n_wr     = 0;
    wr_cyc.delete();
    min_addr = 16'hFFFF;
    max_addr = 16'h0000;
  endtask

  // One clock: entered 1 time unit after a rising edge, leaves 1 unit after the next.
  task automatic step(input bit wr, input logic [7:0] d, input bit rst);
    int          j, slot, idx;
    bit          xfer, e_rd, e_wr;
    logic [15:0] e_addr;
    bus.reg_write = wr;
    bus.reg_d_wr  = d;
    reset         = rst;
    bus.bus_d_in  = prev_rd ? mem(prev_addr) : 8'($urandom);
    #2;
    xfer   = m_active && (m_k > int'(SD));
    j      = xfer ? m_k - 1 - int'(SD) : 0;
    slot   = j % int'(BC);
    idx    = j / int'(BC);
    e_rd   = xfer && (slot == 0);
    e_wr   = xfer && (slot == 1) && !wr;
    e_addr = {m_src, 8'(idx)};
    chk("dma_active", 32'(bus.dma_active), 32'(m_active));
    chk("bus_rd", 32'(bus.bus_rd), 32'(e_rd));
    chk("oam_write", 32'(bus.oam_write), 32'(e_wr));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("reg_d_rd", 32'(bus.reg_d_rd), 32'(m_raw));
    if (e_rd) chk("dma_src_addr", 32'(bus.dma_src_addr), 32'(e_addr));
    if (e_wr) begin
      chk("oam_addr", 32'(bus.oam_addr), 32'(idx));
      chk("oam_d_wr", 32'(bus.oam_d_wr), 32'(mem(e_addr)));
    end
    if (bus.dma_active) n_active++;
    if (bus.done) n_done++;
    if (bus.oam_write) begin
      n_wr++;
      oam[bus.oam_addr] = bus.oam_d_wr;
      wr_cyc.push_back(cyc);
    end
    if (bus.bus_rd) begin
      if (bus.dma_src_addr < min_addr) min_addr = bus.dma_src_addr;
      if (bus.dma_src_addr > max_addr) max_addr = bus.dma_src_addr;
    end
    prev_rd   = e_rd && !rst;
    prev_addr = e_addr;
    @(posedge clk);
    if (rst) begin
      m_active = 0;
      m_done   = 0;
      m_raw    = 8'h00;
      m_src    = 8'h00;
    end else if (wr) begin
      m_active = 1;
      m_k      = 1;
      m_src    = (d >= 8'hE0) ? d - 8'h20 : d;
      m_raw    = d;
      m_done   = 0;
    end else if (m_active) begin
      if (m_k == int'(ACT)) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_k++;
        m_done = 0;
      end
    end else begin
      m_done = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  map_vec_t vecs[7];
  int       a2, d2;

  initial begin
    vecs[0] = '{d: 8'h00, exp_hi: 8'h00};
    vecs[1] = '{d: 8'hC1, exp_hi: 8'hC1};
    vecs[2] = '{d: 8'hDF, exp_hi: 8'hDF};
    vecs[3] = '{d: 8'hE0, exp_hi: 8'hC0};
    vecs[4] = '{d: 8'hF3, exp_hi: 8'hD3};
    vecs[5] = '{d: 8'hFF, exp_hi: 8'hDF};
    vecs[6] = '{d: 8'h80, exp_hi: 8'h80};

    cyc = 0; m_active = 0; m_k = 0; m_src = 0; m_raw = 0; m_done = 0;
    prev_rd = 0; prev_addr = 0;
    clear_counts();
    reset = 1'b1; reset2 = 1'b1;
    bus.reg_write = 1'b0; bus.reg_d_wr = 8'h00; bus.bus_d_in = 8'h00;
    bus2.reg_write = 1'b0; bus2.reg_d_wr = 8'h00; bus2.bus_d_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_dma_active", 32'(bus.dma_active), 0);
    chk("rst_bus_rd", 32'(bus.bus_rd), 0);
    chk("rst_oam_write", 32'(bus.oam_write), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_src_addr", 32'(bus.dma_src_addr), 0);
    chk("rst_oam_addr", 32'(bus.oam_addr), 0);
    chk("rst_oam_d_wr", 32'(bus.oam_d_wr), 0);
    chk("rst_reg_d_rd", 32'(bus.reg_d_rd), 0);

    // Basic copy from C100
    clear_counts();
    step(1'b1, 8'hC1, 1'b0);
    idle_steps(ACT + 3);
    chk("basic_active_cycles", 32'(n_active), 644);
    chk("basic_done_pulses", 32'(n_done), 1);
    chk("basic_oam_writes", 32'(n_wr), 160);
    chk("basic_first_addr", 32'(min_addr), 32'h0000C100);
    chk("basic_last_addr", 32'(max_addr), 32'h0000C19F);
    for (int i = 0; i < 160; i++) chk("basic_oam_data", 32'(oam[i]), 32'(8'(i) ^ 8'h5A));
    for (int i = 1; i < wr_cyc.size(); i++) chk("basic_wr_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 4);

    // Echo mapping
    clear_counts();
    step(1'b1, 8'hF3, 1'b0);
    idle_steps(ACT + 3);
    chk("echo_first_addr", 32'(min_addr), 32'h0000D300);
    chk("echo_last_addr", 32'(max_addr), 32'h0000D39F);
    chk("echo_readback", 32'(bus.reg_d_rd), 32'h000000F3);

    // Restart on the write slot of byte 50
    clear_counts();
    step(1'b1, 8'hC0, 1'b0);
    idle_steps(205);
    step(1'b1, 8'hC2, 1'b0);
    idle_steps(ACT + 3);
    chk("restart_active_cycles", 32'(n_active), 850);
    chk("restart_done_pulses", 32'(n_done), 1);
    chk("restart_oam_writes", 32'(n_wr), 210);
    chk("restart_last_addr", 32'(max_addr), 32'h0000C29F);

    // Reset during byte 10
    step(1'b1, 8'hC1, 1'b0);
    idle_steps(45);
    step(1'b0, 8'h00, 1'b1);
    #1;
    chk("rstmid_dma_active", 32'(bus.dma_active), 0);
    chk("rstmid_oam_write", 32'(bus.oam_write), 0);
    chk("rstmid_reg_d_rd", 32'(bus.reg_d_rd), 0);
    clear_counts();
    idle_steps(50);
    chk("rstmid_no_writes", 32'(n_wr), 0);

    // Write on the final active cycle
    step(1'b1, 8'hC1, 1'b0);
    idle_steps(ACT - 1);
    step(1'b1, 8'hC2, 1'b0);
    clear_counts();
    idle_steps(SD);
    #1;
    chk("collide_no_done", 32'(n_done), 0);
    chk("collide_active", 32'(bus.dma_active), 1);
    chk("collide_bus_rd", 32'(bus.bus_rd), 1);
    chk("collide_restart_addr", 32'(bus.dma_src_addr), 32'h0000C200);
    idle_steps(ACT);

    // Source mapping table; each write restarts the previous one
    foreach (vecs[v]) begin
      step(1'b1, vecs[v].d, 1'b0);
      idle_steps(SD);
      #1;
      chk("map_addr", 32'(bus.dma_src_addr), 32'({vecs[v].exp_hi, 8'h00}));
      chk("map_readback", 32'(bus.reg_d_rd), 32'(vecs[v].d));
    end
    idle_steps(ACT);

    // Random writes and resets against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), 8'($urandom), ($urandom_range(0, 1999) == 0));
    end

    // BYTE_CYCLES=2, START_DELAY=0 instance
    reset2 = 1'b0;
    @(posedge clk);
    #1;
    bus2.reg_write = 1'b1;
    bus2.reg_d_wr  = 8'hC3;
    @(posedge clk);
    #1;
    bus2.reg_write = 1'b0;
    a2 = 0;
    d2 = 0;
    for (int n = 0; n < 330; n++) begin
      bus2.bus_d_in = 8'($urandom);
      #1;
      if (bus2.dma_active) begin
        chk("fast_bus_rd", 32'(bus2.bus_rd), 32'((a2 % 2) == 0));
        chk("fast_oam_write", 32'(bus2.oam_write), 32'((a2 % 2) == 1));
        a2++;
      end
      if (bus2.done) d2++;
      @(posedge clk);
      #1;
    end
    chk("fast_active_cycles", 32'(a2), 320);
    chk("fast_done_pulses", 32'(d2), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
